// File: rtl/barrett677_pkg.sv
// barrett677_pkg: shared constants for the prime-677 Barrett reducer.
//   Q     : modulus (677)
//   K     : Barrett shift (20)
//   MU    : floor(2^K / Q) = 1548
//   IN_W  : operand width (19), OUT_W : residue width (10)
//   P_W   : width of din_a * MU (30), T_W : width of the partial remainder (12)
//   Q_W   : width of the quotient estimate (P_W - K = 10)
package barrett677_pkg;

  localparam int unsigned Q     = 677;
  localparam int unsigned K     = 20;
  localparam int unsigned MU    = 1548;
  localparam int unsigned IN_W  = 19;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned P_W   = 30;
  localparam int unsigned T_W   = 12;
  localparam int unsigned Q_W   = P_W - K;

endpackage

// File: rtl/barrett677_cond_sub.sv
// barrett677_cond_sub: one conditional correction step of the Barrett reducer.
//   x_i : T_W-bit partial remainder
//   y_o : (x_i >= Q) ? x_i - Q : x_i
// Purely combinational.
module barrett677_cond_sub
  import barrett677_pkg::*;
(
  input  logic [T_W-1:0] x_i,
  output logic [T_W-1:0] y_o
);

  always_comb begin
    y_o = x_i;
    if (x_i >= T_W'(Q)) begin
      y_o = x_i - T_W'(Q);
    end
  end

endmodule

// File: rtl/barrett_for_677.sv
// barrett_for_677: streaming Barrett reducer, dout_r = din_a mod 677.
//   clk    : single clock, rising edge
//   rst    : synchronous active-high reset, clears every pipeline register
//   din_a  : 19-bit unsigned operand (0..524287)
//   dout_r : 10-bit registered residue (0..676)
// One result per clock, no handshake.
// Optional macro BARRETT677_PIPE2_EN: adds a register after the partial
// remainder t, splitting multiply/subtract from the two corrections
// (latency 2 instead of 1). Results are identical in both builds.
module barrett_for_677
  import barrett677_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  din_a,
  output logic [OUT_W-1:0] dout_r
);

  logic [P_W-1:0]   p;
  logic [Q_W-1:0]   q;
  logic [IN_W-1:0]  q_times_mod;
  logic [T_W-1:0]   t;
  logic [T_W-1:0]   t_s2;
  logic [T_W-1:0]   t1;
  logic [T_W-1:0]   r;
  logic [OUT_W-1:0] dout_d;
  logic [OUT_W-1:0] dout_q;

  // Quotient estimate undershoots floor(din_a/Q) by at most 2, so t stays
  // below 3*Q and fits T_W bits; q*Q never exceeds din_a, so no wrap.
  always_comb begin
    p           = P_W'(din_a) * P_W'(MU);
    q           = Q_W'(p >> K);
    q_times_mod = IN_W'(q) * IN_W'(Q);
    t           = T_W'(din_a - q_times_mod);
  end

`ifdef BARRETT677_PIPE2_EN
  logic [T_W-1:0] t_d;
  logic [T_W-1:0] t_q;

  always_comb begin
    t_d = t;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  always_comb begin
    t_s2 = t_q;
  end
`else
  always_comb begin
    t_s2 = t;
  end
`endif

  // Two corrections cover the worst-case underestimate of 2.
  barrett677_cond_sub u_sub0 (
    .x_i (t_s2),
    .y_o (t1)
  );

  barrett677_cond_sub u_sub1 (
    .x_i (t1),
    .y_o (r)
  );

  always_comb begin
    dout_d = OUT_W'(r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_r = dout_q;

endmodule

// File: tb/tb_barrett_for_677.sv
// tb_barrett_for_677: scoreboard bench for barrett_for_677.
// Driver issues din_a on the falling edge and queues the hand-computed
// residue; a monitor tracks which edge presents each result and pops and
// compares just after that edge. Define BARRETT677_PIPE2_EN for the 2-stage build.
module tb_barrett_for_677;

`ifdef BARRETT677_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int unsigned din;
    int unsigned exp;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] din_a = 19'd500;
  logic [9:0]  dout_r;

  item_t       exp_q[$];
  logic        pv[LAT];
  logic        cur_issue = 1'b0;
  int          checks = 0;
  int          failures = 0;

  barrett_for_677 dut (
    .clk    (clk),
    .rst    (rst),
    .din_a  (din_a),
    .dout_r (dout_r)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
  end

  // Monitor: on a reset edge every in-flight expectation is dropped and the
  // next LAT outputs must read 0; otherwise the valid marks shift one stage.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        for (int i = 0; i < LAT; i++) begin
          it.din = din_a;
          it.exp = 0;
          exp_q.push_back(it);
          pv[i] = 1'b1;
        end
      end else begin
        for (int i = LAT - 1; i > 0; i--) pv[i] = pv[i-1];
        pv[0] = cur_issue;
      end
      #1;
      if (pv[LAT-1]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL underflow: dout_r=%0d presented, expected queue empty", dout_r);
        end else begin
          it = exp_q.pop_front();
          if (int'(dout_r) != it.exp) begin
            failures++;
            $display("FAIL residue din=%0d: got %0d, want %0d", it.din, dout_r, it.exp);
          end else begin
            $display("txn din=%0d dout_r=%0d ok", it.din, dout_r);
          end
        end
      end
    end
  end

  task automatic send(input int unsigned v, input int unsigned e);
    item_t it;
    @(negedge clk);
    rst       = 1'b0;
    din_a     = v[18:0];
    cur_issue = 1'b1;
    it.din    = v;
    it.exp    = e;
    exp_q.push_back(it);
  endtask

  task automatic reset_edges(input int n, input int unsigned v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b1;
      din_a     = v[18:0];
      cur_issue = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b0;
      cur_issue = 1'b0;
    end
  endtask

  initial begin
    int unsigned v;
    // Reset held for two edges with din_a=500 (rst already 1 from time 0).
    reset_edges(1, 500);
    send(500, 500);

    // Low range identity and the first wrap points.
    for (int unsigned i = 0; i < 677; i++) send(i, i);
    send(677, 0);
    send(678, 1);
    send(1353, 676);
    send(1354, 0);

    // Two corrections needed around 677^2, plus top of range.
    send(458328, 676);
    send(458329, 0);
    send(524287, 289);
    send(523998, 0);
    send(523997, 676);

    // Back-to-back stream.
    send(100, 100);
    send(777, 100);
    send(1454, 100);
    send(524287, 289);
    idle(2);

    // Mid-stream reset for one edge.
    send(100, 100);
    send(777, 100);
    reset_edges(1, 1454);
    send(1454, 100);
    send(524287, 289);
    send(458328, 676);

    // Sweep against a software model: strided plus random.
    for (int unsigned s = 0; s < 524288; s += 523) send(s, s % 677);
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 524287);
      send(v, v % 677);
    end

    idle(LAT + 2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
